// File: rtl/led_pattern.sv
// LED pattern generator: a prescaled step engine that walks a pattern register
// through rotate-left, rotate-right, bounce or binary-count sequences.
// A mode change reloads a seed pattern. step_i forces an immediate advance.
module led_pattern #(
    parameter int LED_W      = 8,
    parameter int PRESCALE   = 256,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             step_i,
    output logic [LED_W-1:0] led_n_o,
    output logic             tick_o
);

    // A prescaler of 1 still needs a one-bit counter so that the types stay legal.
    // The counter then never leaves 0, and every enabled cycle is a tick.
    localparam int               CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    localparam logic [1:0] MODE_ROL    = 2'b00;
    localparam logic [1:0] MODE_ROR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    localparam logic [0:0] DIR_LEFT  = 1'b0;
    localparam logic [0:0] DIR_RIGHT = 1'b1;

    localparam logic [LED_W-1:0] SEED_ONE  = LED_W'(1);
    localparam logic [LED_W-1:0] SEED_ZERO = '0;

    logic [LED_W-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [0:0]       dir_q,     dir_d;
    logic [1:0]       mode_q,    mode_d;
    logic             tick_q,    tick_d;

    logic [LED_W-1:0] adv_pattern;
    logic [0:0]       adv_dir;
    logic             reload;
    logic             presc_tick;

    // Compute the pattern and direction one step ahead for the registered mode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first.
        // A path that leaves one unassigned would otherwise infer a latch.
        adv_pattern = pattern_q;
        adv_dir     = dir_q;
        case (mode_q)
            MODE_ROL: adv_pattern = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
            MODE_ROR: adv_pattern = {pattern_q[0], pattern_q[LED_W-1:1]};
            MODE_BOUNCE: begin
                // The turn happens on the step that hits an end, so there is no dwell there.
                if (dir_q == DIR_LEFT) begin
                    if (pattern_q[LED_W-1]) begin
                        adv_dir     = DIR_RIGHT;
                        adv_pattern = pattern_q >> 1;
                    end else begin
                        adv_pattern = pattern_q << 1;
                    end
                end else begin
                    if (pattern_q[0]) begin
                        adv_dir     = DIR_LEFT;
                        adv_pattern = pattern_q << 1;
                    end else begin
                        adv_pattern = pattern_q >> 1;
                    end
                end
            end
            default: adv_pattern = pattern_q + LED_W'(1);
        endcase
    end

    // Next-state selection by priority: a mode reload, then a step or tick, then counting.
    always_comb begin
        pattern_d  = pattern_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        tick_d     = 1'b0;
        reload     = (mode_i != mode_q);
        presc_tick = en_i && (cnt_q == CNT_LAST);

        if (reload) begin
            mode_d    = mode_i;
            cnt_d     = '0;
            dir_d     = DIR_LEFT;
            pattern_d = (mode_i == MODE_COUNT) ? SEED_ZERO : SEED_ONE;
        end else if (step_i || presc_tick) begin
            // A step that lands on a tick still makes one advance. It also restarts the count.
            pattern_d = adv_pattern;
            dir_d     = adv_dir;
            cnt_d     = '0;
            tick_d    = 1'b1;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers. This reset is asserted HIGH even though the name is rst_n.
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            pattern_q <= SEED_ONE;
            cnt_q     <= '0;
            dir_q     <= DIR_LEFT;
            mode_q    <= MODE_ROL;
            tick_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            // Every flop then samples the values from before the edge.
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            tick_q    <= tick_d;
        end
    end

    // The LED drive comes straight from the pattern register, with optional inversion.
    always_comb begin
        led_n_o = ACTIVE_LOW ? ~pattern_q : pattern_q;
        tick_o  = tick_q;
    end

endmodule

// File: tb/tb_led_pattern.sv
// Directed testbench for led_pattern with LED_W=8, PRESCALE=4 and ACTIVE_LOW=1.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_led_pattern;

    logic       clk_i   = 1'b0;
    logic       rst_n   = 1'b1;
    logic       en_i    = 1'b0;
    logic [1:0] mode_i  = 2'b00;
    logic       step_i  = 1'b0;
    logic [7:0] led_n_o;
    logic       tick_o;

    int n_tests = 0;
    int n_fail  = 0;

    led_pattern #(
        .LED_W      (8),
        .PRESCALE   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .en_i    (en_i),
        .mode_i  (mode_i),
        .step_i  (step_i),
        .led_n_o (led_n_o),
        .tick_o  (tick_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Hold reset for two edges, then release it with the given mode and enable.
    task automatic do_reset(input logic [1:0] m, input logic e);
        rst_n  = 1'b1;
        step_i = 1'b0;
        en_i   = 1'b0;
        mode_i = m;
        cyc();
        cyc();
        rst_n = 1'b0;
        en_i  = e;
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        mode_i = 2'b00;
        en_i   = 1'b1;
        cyc();
        cyc();
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b0, 8'hFE}) begin
            n_fail++;
            $display("FAIL reset_state: tick/led got %b/%h exp 0/fe", tick_o, led_n_o);
        end
    endtask

    task automatic test_rotate_left();
        logic [7:0] exp_pat;
        logic       exp_tick;
        do_reset(2'b00, 1'b1);
        exp_pat = 8'h01;
        for (int e = 1; e <= 32; e++) begin
            cyc();
            exp_tick = ((e % 4) == 0);
            if (exp_tick) exp_pat = {exp_pat[6:0], exp_pat[7]};
            n_tests++;
            if ({tick_o, led_n_o} !== {exp_tick, ~exp_pat}) begin
                n_fail++;
                $display("FAIL rol_edge%0d: tick/led got %b/%h exp %b/%h",
                         e, tick_o, led_n_o, exp_tick, ~exp_pat);
            end
        end
    endtask

    task automatic test_bounce();
        int         idx_tab [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        logic [7:0] one = 8'h01;
        logic [7:0] exp_led;
        do_reset(2'b10, 1'b0);
        cyc();
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b0, 8'hFE}) begin
            n_fail++;
            $display("FAIL bounce_reload: tick/led got %b/%h exp 0/fe", tick_o, led_n_o);
        end
        step_i = 1'b1;
        for (int s = 0; s < 15; s++) begin
            cyc();
            exp_led = ~(one << idx_tab[s]);
            n_tests++;
            if ({tick_o, led_n_o} !== {1'b1, exp_led}) begin
                n_fail++;
                $display("FAIL bounce_step%0d: tick/led got %b/%h exp 1/%h",
                         s + 1, tick_o, led_n_o, exp_led);
            end
        end
        step_i = 1'b0;
    endtask

    task automatic test_count();
        logic [7:0] exp_pat;
        do_reset(2'b11, 1'b0);
        cyc();
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL count_reload: tick/led got %b/%h exp 0/ff", tick_o, led_n_o);
        end
        step_i = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            cyc();
            exp_pat = 8'(k);
            n_tests++;
            if ({tick_o, led_n_o} !== {1'b1, ~exp_pat}) begin
                n_fail++;
                $display("FAIL count_step%0d: tick/led got %b/%h exp 1/%h",
                         k, tick_o, led_n_o, ~exp_pat);
            end
        end
        step_i = 1'b0;
    endtask

    task automatic test_enable_hold();
        // After 6 edges the pattern is 02 and two counts are already taken.
        do_reset(2'b00, 1'b1);
        for (int e = 1; e <= 6; e++) cyc();
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b0, 8'hFD}) begin
            n_fail++;
            $display("FAIL hold_pre: tick/led got %b/%h exp 0/fd", tick_o, led_n_o);
        end
        en_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            n_tests++;
            if ({tick_o, led_n_o} !== {1'b0, 8'hFD}) begin
                n_fail++;
                $display("FAIL hold_cyc%0d: tick/led got %b/%h exp 0/fd", c, tick_o, led_n_o);
            end
        end
        // Two counts remain before the next tick.
        en_i = 1'b1;
        cyc();
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b0, 8'hFD}) begin
            n_fail++;
            $display("FAIL hold_resume1: tick/led got %b/%h exp 0/fd", tick_o, led_n_o);
        end
        cyc();
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b1, 8'hFB}) begin
            n_fail++;
            $display("FAIL hold_resume2: tick/led got %b/%h exp 1/fb", tick_o, led_n_o);
        end
        cyc();
        step_i = 1'b1;
        cyc();
        step_i = 1'b0;
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b1, 8'hF7}) begin
            n_fail++;
            $display("FAIL hold_step: tick/led got %b/%h exp 1/f7", tick_o, led_n_o);
        end
        // The step cleared the count, so the next tick comes four edges later.
        for (int e = 1; e <= 3; e++) begin
            cyc();
            n_tests++;
            if ({tick_o, led_n_o} !== {1'b0, 8'hF7}) begin
                n_fail++;
                $display("FAIL hold_after_step%0d: tick/led got %b/%h exp 0/f7", e, tick_o, led_n_o);
            end
        end
        cyc();
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b1, 8'hEF}) begin
            n_fail++;
            $display("FAIL hold_next_tick: tick/led got %b/%h exp 1/ef", tick_o, led_n_o);
        end
    endtask

    task automatic test_mode_change();
        do_reset(2'b00, 1'b1);
        for (int e = 1; e <= 7; e++) cyc();
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b0, 8'hFD}) begin
            n_fail++;
            $display("FAIL mchg_pre: tick/led got %b/%h exp 0/fd", tick_o, led_n_o);
        end
        // Edge 8 brings a tick, a step and a mode change together. The reload wins.
        mode_i = 2'b01;
        step_i = 1'b1;
        cyc();
        step_i = 1'b0;
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b0, 8'hFE}) begin
            n_fail++;
            $display("FAIL mchg_reload: tick/led got %b/%h exp 0/fe", tick_o, led_n_o);
        end
        for (int e = 1; e <= 3; e++) begin
            cyc();
            n_tests++;
            if ({tick_o, led_n_o} !== {1'b0, 8'hFE}) begin
                n_fail++;
                $display("FAIL mchg_wait%0d: tick/led got %b/%h exp 0/fe", e, tick_o, led_n_o);
            end
        end
        cyc();
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b1, 8'h7F}) begin
            n_fail++;
            $display("FAIL mchg_ror: tick/led got %b/%h exp 1/7f", tick_o, led_n_o);
        end
    endtask

    task automatic test_reset_mid_bounce();
        do_reset(2'b10, 1'b0);
        cyc();
        step_i = 1'b1;
        for (int s = 1; s <= 9; s++) cyc();
        step_i = 1'b0;
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b1, 8'hDF}) begin
            n_fail++;
            $display("FAIL midrst_pre: tick/led got %b/%h exp 1/df", tick_o, led_n_o);
        end
        // Assert reset between clock edges. The outputs must change at once.
        #2;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b0, 8'hFE}) begin
            n_fail++;
            $display("FAIL midrst_async: tick/led got %b/%h exp 0/fe", tick_o, led_n_o);
        end
        cyc();
        cyc();
        rst_n  = 1'b0;
        step_i = 1'b1;
        cyc();
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b0, 8'hFE}) begin
            n_fail++;
            $display("FAIL midrst_reload: tick/led got %b/%h exp 0/fe", tick_o, led_n_o);
        end
        cyc();
        step_i = 1'b0;
        n_tests++;
        if ({tick_o, led_n_o} !== {1'b1, 8'hFD}) begin
            n_fail++;
            $display("FAIL midrst_first_step: tick/led got %b/%h exp 1/fd", tick_o, led_n_o);
        end
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_bounce();
        test_count();
        test_enable_hold();
        test_mode_change();
        test_reset_mid_bounce();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net in case the simulation stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish exp finish");
        $fatal(1);
    end

endmodule

// File: doc/led_pattern.md
LED_PATTERN -- requirements
Module: led_pattern

Interface
REQ-001 SHALL have parameter LED_W, default 8, meaning number of LED outputs (legal range 2..32).
REQ-002 SHALL have parameter PRESCALE, default 256, meaning clk_i cycles per pattern step (legal range 1..2^24).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = LED on drives 0, 0 = LED on drives 1.
REQ-004 SHALL have port clk_i  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en_i  input  1  1 = prescaler runs; 0 = prescaler and pattern hold.
REQ-007 SHALL have port mode_i  input  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 binary count.
REQ-008 SHALL have port step_i  input  1  single-cycle request to advance one step immediately.
REQ-009 SHALL have port led_n_o  output  LED_W  LED drive = pattern, inverted when ACTIVE_LOW=1.
REQ-010 SHALL have port tick_o  output  1  one-cycle pulse marking a pattern advance.

Function
REQ-011 SHALL hold internal state: pattern[LED_W-1:0], prescaler count cnt, bounce direction dir (LEFT/RIGHT), registered mode mode_q.
REQ-012 SHALL, when en_i=1, increment cnt each cycle and raise an internal tick when cnt==PRESCALE-1, clearing cnt to 0 on the same edge; PRESCALE=1 ticks every cycle.
REQ-013 SHALL hold cnt unchanged while en_i=0.
REQ-014 SHALL advance the pattern by one step on each tick or step_i=1, per mode_q.
REQ-015 SHALL, in rotate-left, set pattern <= {pattern[LED_W-2:0], pattern[LED_W-1]}.
REQ-016 SHALL, in rotate-right, set pattern <= {pattern[0], pattern[LED_W-1:1]}.
REQ-017 SHALL, in bounce, shift left while dir=LEFT and right while dir=RIGHT; on a step with dir=LEFT and pattern[LED_W-1]=1, set dir=RIGHT and shift right; on a step with dir=RIGHT and pattern[0]=1, set dir=LEFT and shift left (no dwell at ends).
REQ-018 SHALL, in binary count, set pattern <= pattern+1 modulo 2^LED_W (all-ones wraps to 0).
REQ-019 SHALL compare mode_i with mode_q every cycle; on mismatch, on that edge: mode_q <= mode_i, cnt <= 0, dir <= LEFT, pattern <= seed (seed = 1 for modes 00/01/10, 0 for mode 11).
REQ-020 SHALL apply priority reload (REQ-019) > step_i > prescaler tick; a step_i coinciding with a tick produces exactly one advance.
REQ-021 SHALL clear cnt to 0 when step_i causes an advance.
REQ-022 SHALL assert tick_o for exactly the one cycle following each edge on which the pattern advanced; tick_o SHALL stay 0 for reloads.
REQ-023 SHALL drive led_n_o directly from the pattern register (no extra latency); the new pattern is visible in the same cycle tick_o is high.
REQ-024 SHALL, with en_i=1 held and no step_i or mode change, produce the first advance on the PRESCALE-th rising edge after reset deassertion and every PRESCALE edges thereafter.

Reset
REQ-025 SHALL, while rst_n=1, asynchronously force pattern=1, cnt=0, dir=LEFT, mode_q=00, tick_o=0.
REQ-026 SHALL, under reset with ACTIVE_LOW=1 and LED_W=8, drive led_n_o=8'hFE.
REQ-027 SHALL, on reset asserted mid-step or mid-bounce, discard all state; operation resumes from REQ-025 values after release.
REQ-028 SHALL, if mode_i!=00 at reset release, perform a REQ-019 reload on the first edge after release.

Verification (LED_W=8, PRESCALE=4, ACTIVE_LOW=1 unless stated)
REQ-029 SHALL cover: reset, mode 00, en_i=1 for 32 cycles -> led_n_o FE,FD,FB,F7,EF,DF,BF,7F,FE at every 4th edge, tick_o pulse with each change.
REQ-030 SHALL cover: mode 10 for 15 steps -> one-hot index 0,1..7,6..0,1 (7F then BF; FE then FD), dir flips exactly at ends.
REQ-031 SHALL cover: mode 11 from seed 0, 256 steps -> pattern counts 00..FF then wraps to 00 (led_n_o FF..00..FF).
REQ-032 SHALL cover: en_i=0 for 20 cycles mid-count -> led_n_o and cnt frozen, no tick_o; en_i=1 resumes remaining count; then step_i pulse -> advance next edge, cnt=0.
REQ-033 SHALL cover: mode_i change 00->01 coincident with tick and step_i -> reload to FE, no tick_o, next advance 4 edges later giving 7F.
REQ-034 SHALL cover: rst_n pulsed mid-bounce with dir=RIGHT -> led_n_o=FE immediately, first post-reset step goes to FD.
